// File: rtl/ram_access_ctrl_if.sv
// Request/response and RAM-pin bundle for ram_access_ctrl.
// The master side is the requester and RAM environment; the slave side is the controller.
interface ram_access_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [LEN_WIDTH-1:0]  req_len;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_last;
    logic                  ram_write_enb;
    logic                  ram_read_enb;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [DATA_WIDTH-1:0] ram_data_out;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready, ram_data_out,
        input  req_ready, rsp_valid, rsp_data, rsp_last,
        input  ram_write_enb, ram_read_enb, ram_address, ram_data_in, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready, ram_data_out,
        output req_ready, rsp_valid, rsp_data, rsp_last,
        output ram_write_enb, ram_read_enb, ram_address, ram_data_in, busy
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Single-port RAM initiator: one-cycle writes, burst reads with RD_LAT wait per beat.
// Latency 2+RD_LAT cycles per read beat; rsp backpressure stalls in RESP with no RAM access.
module ram_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = 4,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    ram_access_ctrl_if.slave  bus
);
    localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_last_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  ram_write_enb_q;
    logic                  ram_read_enb_q;
    logic [ADDR_WIDTH-1:0] ram_address_q;
    logic [DATA_WIDTH-1:0] ram_data_in_q;
    logic                  busy_q;

    logic                  last_d;
    logic [ADDR_WIDTH-1:0] addr_inc_d;

    always_comb begin
        last_d     = (beat_q == len_q);
        addr_inc_d = addr_q + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            len_q           <= '0;
            beat_q          <= '0;
            cnt_q           <= '0;
            req_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_last_q      <= 1'b0;
            rsp_data_q      <= '0;
            ram_write_enb_q <= 1'b0;
            ram_read_enb_q  <= 1'b0;
            ram_address_q   <= '0;
            ram_data_in_q   <= '0;
            busy_q          <= 1'b0;
        end else begin
            // Enables are single-cycle pulses; only the states below re-raise them.
            ram_write_enb_q <= 1'b0;
            ram_read_enb_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        addr_q        <= bus.req_addr;
                        len_q         <= bus.req_len;
                        beat_q        <= '0;
                        ram_address_q <= bus.req_addr;
                        if (bus.req_write) begin
                            ram_data_in_q   <= bus.req_wdata;
                            ram_write_enb_q <= 1'b1;
                            state_q         <= WRITE;
                        end else begin
                            ram_read_enb_q <= 1'b1;
                            state_q        <= READ;
                        end
                    end
                end
                WRITE: begin
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                READ: begin
                    cnt_q   <= CNT_W'(RD_LAT);
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_data_q  <= bus.ram_data_out;
                        rsp_last_q  <= last_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_last_q  <= 1'b0;
                        if (rsp_last_q) begin
                            busy_q      <= 1'b0;
                            req_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            beat_q         <= beat_q + LEN_WIDTH'(1);
                            addr_q         <= addr_inc_d;
                            ram_address_q  <= addr_inc_d;
                            ram_read_enb_q <= 1'b1;
                            state_q        <= READ;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_last      = rsp_last_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.ram_write_enb = ram_write_enb_q;
    assign bus.ram_read_enb  = ram_read_enb_q;
    assign bus.ram_address   = ram_address_q;
    assign bus.ram_data_in   = ram_data_in_q;
    assign bus.busy          = busy_q;
endmodule
